// File: rtl/priv_ext_csr_requester.sv
// priv_ext_csr_requester: initiator side of the privilege extension CSR bus.
// Runs one CSRRW/CSRRS/CSRRC as a read phase, an optional one-cycle write
// strobe and a valid/ready response carrying the old value or illegal flag.
// Ports: CLK/RST (sync, active high); req_* request in; rsp_* response out;
// flush aborts; ext_* drive/observe extension responders (e.g. PMP).
// Optional: define PRIV_EXT_CSR_RO_CHECK_EN to reject writes to 0xC00-0xFFF
// on accept without touching the extension bus.
module priv_ext_csr_requester #(
  parameter int TIMEOUT_CYCLES = 4,
  parameter int WAIT_CNT_W     = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_no_write,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal,
  output logic [11:0] ext_csr_addr,
  output logic        ext_csr_active,
  output logic [31:0] ext_value_in,
  input  logic [31:0] ext_value_out,
  input  logic        ext_ack,
  input  logic        ext_invalid_csr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP
  } state_e;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST =
    WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [11:0]           addr_q, addr_d;
  logic [11:0]           hold_q, hold_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  nowr_q, nowr_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           old_q, old_d;
  logic [31:0]           new_q, new_d;
  logic                  ill_q, ill_d;

  logic                  accept;
  logic                  ro_hit;
  logic [31:0]           merged;

`ifdef PRIV_EXT_CSR_RO_CHECK_EN
  assign ro_hit = (req_addr[11:10] == 2'b11) &&
                  ((req_op == OP_RW) || !req_no_write);
`else
  assign ro_hit = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && req_valid && !flush;

  always_comb begin
    merged = wdata_q;
    unique case (op_q)
      OP_RS:   merged = ext_value_out | wdata_q;
      OP_RC:   merged = ext_value_out & ~wdata_q;
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    nowr_d  = nowr_q;
    cnt_d   = cnt_q;
    old_d   = old_q;
    new_d   = new_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          nowr_d  = req_no_write;
          cnt_d   = '0;
          old_d   = '0;
          ill_d   = 1'b0;
          if (req_op == 2'b00 || ro_hit) begin
            ill_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        hold_d = addr_q;
        if (flush) begin
          state_d = S_IDLE;
        end else if (ext_invalid_csr) begin
          ill_d   = 1'b1;
          old_d   = '0;
          state_d = S_RSP;
        end else if (ext_ack) begin
          old_d   = ext_value_out;
          new_d   = merged;
          state_d = nowr_q ? S_RSP : S_WR;
        end else if (cnt_q == CNT_LAST) begin
          ill_d   = 1'b1;
          old_d   = '0;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // The strobe always commits; flush only drops the response.
      S_WR: state_d = flush ? S_IDLE : S_RSP;
      S_RSP: begin
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      hold_q  <= '0;
      wdata_q <= '0;
      nowr_q  <= 1'b0;
      cnt_q   <= '0;
      old_q   <= '0;
      new_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      nowr_q  <= nowr_d;
      cnt_q   <= cnt_d;
      old_q   <= old_d;
      new_q   <= new_d;
      ill_q   <= ill_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE) && !flush;
  assign rsp_valid      = (state_q == S_RSP);
  assign rsp_rdata      = rsp_valid ? old_q : 32'h0;
  assign rsp_illegal    = rsp_valid && ill_q;
  assign ext_csr_active = (state_q == S_WR);
  // Bus address only follows the latched request during an ext access.
  assign ext_csr_addr   = (state_q == S_RD || state_q == S_WR) ?
                          addr_q : hold_q;
  assign ext_value_in   = new_q;

endmodule

// File: doc/priv_ext_csr_requester.md
Name: priv_ext_csr_requester

Overview:
- Initiator side of the privilege extension CSR interface. Drives the CSR address, the active strobe and the write value into extension units such as the PMP, and consumes their ack, read value and invalid flag.
- Sits between the CSR-instruction path of the privilege unit and the extension bus.
- Converts a single CSRRW/CSRRS/CSRRC request into a sequenced read phase, then an optional one-cycle write strobe.
- Returns the old CSR value, or an illegal-instruction flag, on a valid/ready response handshake.

Parameters:
TIMEOUT_CYCLES, 4, read-phase cycles to wait for ext_ack before declaring the CSR illegal (must be ≥1)
WAIT_CNT_W, 3, counter width; must satisfy 2^WAIT_CNT_W ≥ TIMEOUT_CYCLES

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  1  CSR request present
req_ready  out  1  block can accept request
req_op  in  2  01=RW, 10=RS, 11=RC, 00=reserved
req_addr  in  12  CSR address
req_wdata  in  32  rs1 value or zimm operand
req_no_write  in  1  suppress write phase (RS/RC with rs1=x0)
flush  in  1  abort outstanding request
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  old CSR value
rsp_illegal  out  1  access illegal
ext_csr_addr  out  12  address to extension units
ext_csr_active  out  1  write strobe; responders update on the clock edge where it is high
ext_value_in  out  32  write value
ext_value_out  in  32  read value from responder, combinational on ext_csr_addr
ext_ack  in  1  responder owns ext_csr_addr, combinational
ext_invalid_csr  in  1  responder rejects access

Behaviour:
- States: IDLE, RD, WR, RSP. Reset (RST high at posedge) forces IDLE and clears all latched data.
- Output values after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0, ext_csr_active=0, ext_csr_addr=0, ext_value_in=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr, wdata and no_write.
  - op=00 goes to RSP with illegal=1 and no ext access.
  - Any other op goes to RD with the wait counter cleared.
- RD:
  - ext_csr_addr=latched addr, ext_csr_active=0.
  - ext_invalid_csr=1 takes priority: illegal=1, rdata=0, go to RSP.
  - Otherwise ext_ack=1: capture old=ext_value_out. Then go to RSP if no_write=1, else go to WR.
  - No ack: increment the counter. When counter==TIMEOUT_CYCLES-1 with no ack, set illegal=1 and go to RSP.
  - Minimum read latency is 1 cycle.
- New value is computed in RD from the captured old value and registered:
  - RW: new = wdata
  - RS: new = old | wdata
  - RC: new = old & ~wdata
- WR:
  - ext_csr_active=1 for exactly one cycle, ext_csr_addr=latched addr, ext_value_in=new.
  - Always proceeds to RSP.
  - ext_ack and ext_invalid_csr are ignored in this state.
- RSP:
  - rsp_valid=1 with rsp_rdata=old (0 if illegal) and rsp_illegal.
  - Outputs hold stable until rsp_ready; return to IDLE in the cycle after the handshake.
  - No new request is accepted in the handshake cycle, so back-to-back throughput is one request per 3 cycles minimum.
- flush:
  - In RD: abort to IDLE with no write strobe.
  - In WR: ignored; the write commits, then the block aborts to IDLE without a response.
  - In RSP: drop the response and go to IDLE; a simultaneous rsp_ready is ignored.
  - In IDLE: blocks acceptance for that cycle.
- RST asserted while in WR: ext_csr_active is 0 in the following cycle, and no partial write is repeated.
- ext_csr_active is never high outside WR.
- When not in RD or WR, ext_csr_addr holds its last value and ext_csr_active=0.

Optional Feature:
PRIV_EXT_CSR_RO_CHECK_EN:
- Defined: on accept, if req_addr[11:10]==2'b11 and the access writes (op=RW, or RS/RC with no_write=0), the block goes directly to RSP with illegal=1 and issues no ext access.
- Undefined: no address-based check; read-only enforcement is left to responders via ext_invalid_csr.

Test Plan:
- CSRRW addr=0x3A0 wdata=0x0000_1F1F; responder acks with value_out=0x0000_0707 → one ext_csr_active pulse with ext_value_in=0x0000_1F1F; rsp_rdata=0x0000_0707, rsp_illegal=0.
- CSRRS addr=0x3B2 wdata=0x0000_00F0 with old=0x0000_000F → ext_value_in=0x0000_00FF; CSRRC with the same inputs → ext_value_in=0x0000_000F. RS with no_write=1 → no active pulse, rdata=0x0000_000F.
- Addr=0x7C0 with ext_ack held 0 and TIMEOUT_CYCLES=4 → RSP entered after 4 RD cycles, rsp_illegal=1, rsp_rdata=0, no active pulse.
- ext_invalid_csr=1 with ext_ack=1 in the first RD cycle → rsp_illegal=1, no write; rsp_ready held low for 5 cycles → rsp_valid and data stay stable.
- flush in RD → IDLE, no pulse. flush in WR → exactly one pulse, then no rsp_valid. RST in WR → ext_csr_active=0 next cycle, req_ready=1.
- With PRIV_EXT_CSR_RO_CHECK_EN: CSRRW addr=0xC00 → rsp_illegal=1 and ext bus idle; CSRRS addr=0xC00 with no_write=1 → read proceeds normally.
